// File: rtl/bnn_infer_sched.sv
`default_nettype none
// ============================================================================
// Module   : bnn_infer_sched
// Purpose  : Per-sample scheduler for the BNN classifier core. It provides a
//            feature FIFO, a start/done handshake guarded by a watchdog, and a
//            valid/ready result port.
// Options  : define BNN_SCHED_STATS_EN to add saturating result counters
// Revision : 1.0 - initial release
// ============================================================================
module bnn_infer_sched #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_features,
   output logic        core_start,
   output logic [15:0] core_features,
   input  logic        core_done,
   input  logic [2:0]  core_class,
   input  logic [3:0]  core_hidden,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [2:0]  out_class,
   output logic [3:0]  out_hidden,
   output logic        out_timeout,
   output logic        busy,
   output logic [4:0]  fifo_count
`ifdef BNN_SCHED_STATS_EN
   ,
   output logic [7:0]  stat_class0,
   output logic [7:0]  stat_class1,
   output logic [7:0]  stat_timeout
`endif
);

   localparam int                 c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
   localparam logic [4:0]         c_DEPTH   = 5'(FIFO_DEPTH);
   localparam logic [7:0]         c_WD_LAST = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t             r_state;
   logic [15:0]        r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [4:0]         r_count;
   logic [7:0]         r_wd;
   logic               r_core_start;
   logic [15:0]        r_core_features;
   logic               r_out_valid;
   logic [2:0]         r_out_class;
   logic [3:0]         r_out_hidden;
   logic               r_out_timeout;

   logic               w_push;
   logic               w_pop;
   logic               w_timeout_hit;

   // Full check ignores a same-cycle pop so a full FIFO always refuses.
   assign in_ready      = (r_count != c_DEPTH);
   assign w_push        = in_valid && in_ready;
   assign w_timeout_hit = (r_wd == c_WD_LAST);
   assign w_pop         = (r_state == ST_WAIT) && (core_done || w_timeout_hit);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_features;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= 5'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 5'd1;
            2'b01:   r_count <= r_count - 5'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // The watchdog value during WAIT cycle k is k-1, so the abort lands on
   // WAIT cycle TIMEOUT_CYCLES; a done on that same cycle takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_wd            <= 8'd0;
         r_core_start    <= 1'b0;
         r_core_features <= 16'd0;
         r_out_valid     <= 1'b0;
         r_out_class     <= 3'd0;
         r_out_hidden    <= 4'd0;
         r_out_timeout   <= 1'b0;
      end else begin
         r_core_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_count != 5'd0) begin
                  r_state         <= ST_ISSUE;
                  r_core_start    <= 1'b1;
                  r_core_features <= r_mem[r_rd_ptr];
               end
            end
            ST_ISSUE: begin
               r_wd    <= 8'd0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               r_wd <= r_wd + 8'd1;
               if (core_done) begin
                  r_out_class   <= core_class;
                  r_out_hidden  <= core_hidden;
                  r_out_timeout <= 1'b0;
                  r_out_valid   <= 1'b1;
                  r_state       <= ST_HOLD;
               end else if (w_timeout_hit) begin
                  r_out_class   <= 3'd0;
                  r_out_hidden  <= 4'd0;
                  r_out_timeout <= 1'b1;
                  r_out_valid   <= 1'b1;
                  r_state       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign core_start    = r_core_start;
   assign core_features = r_core_features;
   assign out_valid     = r_out_valid;
   assign out_class     = r_out_class;
   assign out_hidden    = r_out_hidden;
   assign out_timeout   = r_out_timeout;
   assign fifo_count    = r_count;
   assign busy          = (r_state != ST_IDLE) || (r_count != 5'd0);

`ifdef BNN_SCHED_STATS_EN
   logic [7:0] r_stat_class0;
   logic [7:0] r_stat_class1;
   logic [7:0] r_stat_timeout;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_class0  <= 8'd0;
         r_stat_class1  <= 8'd0;
         r_stat_timeout <= 8'd0;
      end else if (r_out_valid && out_ready) begin
         if (r_out_timeout) begin
            if (r_stat_timeout != 8'hFF) r_stat_timeout <= r_stat_timeout + 8'd1;
         end else if (r_out_class == 3'd0) begin
            if (r_stat_class0 != 8'hFF) r_stat_class0 <= r_stat_class0 + 8'd1;
         end else begin
            if (r_stat_class1 != 8'hFF) r_stat_class1 <= r_stat_class1 + 8'd1;
         end
      end
   end

   assign stat_class0  = r_stat_class0;
   assign stat_class1  = r_stat_class1;
   assign stat_timeout = r_stat_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bnn_infer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bnn_infer_sched
// Purpose  : Directed self-checking bench for bnn_infer_sched
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bnn_infer_sched;

   localparam int FIFO_DEPTH     = 4;
   localparam int TIMEOUT_CYCLES = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_features = 16'd0;
   logic        core_start;
   logic [15:0] core_features;
   logic        core_done = 1'b0;
   logic [2:0]  core_class = 3'd7;
   logic [3:0]  core_hidden = 4'hF;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  out_class;
   logic [3:0]  out_hidden;
   logic        out_timeout;
   logic        busy;
   logic [4:0]  fifo_count;
`ifdef BNN_SCHED_STATS_EN
   logic [7:0]  stat_class0;
   logic [7:0]  stat_class1;
   logic [7:0]  stat_timeout;
`endif

   always #5 clk = ~clk;

   bnn_infer_sched #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_features   (in_features),
      .core_start    (core_start),
      .core_features (core_features),
      .core_done     (core_done),
      .core_class    (core_class),
      .core_hidden   (core_hidden),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_class     (out_class),
      .out_hidden    (out_hidden),
      .out_timeout   (out_timeout),
      .busy          (busy),
      .fifo_count    (fifo_count)
`ifdef BNN_SCHED_STATS_EN
      ,
      .stat_class0   (stat_class0),
      .stat_class1   (stat_class1),
      .stat_timeout  (stat_timeout)
`endif
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] starts[$];

   always @(negedge clk) begin
      if (!rst && core_start) starts.push_back(core_features);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] f);
      int n = 0;
      while (!in_ready && n < 100) begin
         tick;
         n++;
      end
      if (!in_ready) check("push_wait", 32'(in_ready), 32'd1);
      in_valid    = 1'b1;
      in_features = f;
      tick;
      in_valid    = 1'b0;
   endtask

   task automatic wait_start;
      int n = 0;
      while (!core_start && n < 100) begin
         tick;
         n++;
      end
      check("start_seen", 32'(core_start), 32'd1);
   endtask

   task automatic wait_valid;
      int n = 0;
      while (!out_valid && n < 100) begin
         tick;
         n++;
      end
      check("valid_seen", 32'(out_valid), 32'd1);
   endtask

   // Called while the core is in ISSUE; done lands on WAIT cycle k.
   task automatic done_at(input int k, input logic [2:0] c, input logic [3:0] h);
      repeat (k) tick;
      core_done   = 1'b1;
      core_class  = c;
      core_hidden = h;
      tick;
      core_done   = 1'b0;
      core_class  = 3'd7;
      core_hidden = 4'hF;
   endtask

   task automatic handshake;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      check("hs_drop", 32'(out_valid), 32'd0);
   endtask

   logic [15:0] exp_q [4];

   initial begin
      repeat (3) tick;
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_core_start", 32'(core_start), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_features", 32'(core_features), 32'd0);

      // Single sample, done on WAIT cycle 2
      starts.delete();
      push(16'h8F0A);
      check("s1_count", 32'(fifo_count), 32'd1);
      check("s1_busy", 32'(busy), 32'd1);
      check("s1_nostart", 32'(core_start), 32'd0);
      tick;
      check("s1_start", 32'(core_start), 32'd1);
      check("s1_feat", 32'(core_features), 32'h8F0A);
      done_at(2, 3'd1, 4'b1010);
      check("s1_valid", 32'(out_valid), 32'd1);
      check("s1_class", 32'(out_class), 32'd1);
      check("s1_hidden", 32'(out_hidden), 32'hA);
      check("s1_to", 32'(out_timeout), 32'd0);
      check("s1_popped", 32'(fifo_count), 32'd0);
      repeat (3) tick;
      check("s1_hold_valid", 32'(out_valid), 32'd1);
      check("s1_hold_class", 32'(out_class), 32'd1);
      check("s1_hold_feat", 32'(core_features), 32'h8F0A);
      handshake;
      check("s1_idle_busy", 32'(busy), 32'd0);
      check("s1_nstarts", 32'(starts.size()), 32'd1);

      // FIFO full, 5th push refused, first sample times out, order on drain
      starts.delete();
      exp_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 4; i++) push(exp_q[i]);
      check("full_count", 32'(fifo_count), 32'd4);
      check("full_in_ready", 32'(in_ready), 32'd0);
      in_valid    = 1'b1;
      in_features = 16'h5555;
      tick;
      in_valid    = 1'b0;
      check("full_refused", 32'(fifo_count), 32'd4);
      wait_valid;
      check("full_first_to", 32'(out_timeout), 32'd1);
      check("full_first_cls", 32'(out_class), 32'd0);
      check("full_pop", 32'(fifo_count), 32'd3);
      handshake;
      for (int i = 1; i < 4; i++) begin
         wait_start;
         done_at(1, 3'(i), 4'(i));
         wait_valid;
         check("drain_class", 32'(out_class), 32'(i));
         check("drain_to", 32'(out_timeout), 32'd0);
         handshake;
      end
      check("drain_count", 32'(fifo_count), 32'd0);
      check("drain_nstarts", 32'(starts.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < starts.size()) check("drain_order", 32'(starts[i]), 32'(exp_q[i]));
      end

      // Exact timeout: abort after WAIT cycle 15
      push(16'hC3A5);
      tick;
      check("to_start", 32'(core_start), 32'd1);
      repeat (TIMEOUT_CYCLES) tick;
      check("to_wait15", 32'(out_valid), 32'd0);
      tick;
      check("to_valid", 32'(out_valid), 32'd1);
      check("to_flag", 32'(out_timeout), 32'd1);
      check("to_class", 32'(out_class), 32'd0);
      check("to_hidden", 32'(out_hidden), 32'd0);
      check("to_pop", 32'(fifo_count), 32'd0);
      handshake;

      // Done on WAIT cycle 15 beats the watchdog
      push(16'h0F0F);
      tick;
      check("tie_start", 32'(core_start), 32'd1);
      done_at(TIMEOUT_CYCLES, 3'd5, 4'd3);
      check("tie_valid", 32'(out_valid), 32'd1);
      check("tie_to", 32'(out_timeout), 32'd0);
      check("tie_class", 32'(out_class), 32'd5);
      check("tie_hidden", 32'(out_hidden), 32'd3);
      core_done   = 1'b1;
      core_class  = 3'd2;
      core_hidden = 4'd9;
      tick;
      core_done   = 1'b0;
      check("hold_done_ign", 32'(out_class), 32'd5);
      check("hold_hid_ign", 32'(out_hidden), 32'd3);
      handshake;
      core_done = 1'b1;
      tick;
      core_done = 1'b0;
      tick;
      check("idle_done_ign", 32'(out_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);

      // Push and pop in the same cycle
      push(16'hAAAA);
      tick;
      check("pp_start", 32'(core_start), 32'd1);
      tick;
      core_done   = 1'b1;
      core_class  = 3'd6;
      core_hidden = 4'hC;
      in_valid    = 1'b1;
      in_features = 16'hBBBB;
      tick;
      core_done   = 1'b0;
      in_valid    = 1'b0;
      check("pp_count", 32'(fifo_count), 32'd1);
      check("pp_valid", 32'(out_valid), 32'd1);
      check("pp_class", 32'(out_class), 32'd6);
      handshake;
      wait_start;
      check("pp_next_feat", 32'(core_features), 32'hBBBB);
      done_at(1, 3'd0, 4'd0);
      wait_valid;
      handshake;

      // Reset mid-WAIT with three queued samples
      push(16'hD001);
      push(16'hD002);
      push(16'hD003);
      tick;
      tick;
      check("mr_count", 32'(fifo_count), 32'd3);
      check("mr_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("mr_count0", 32'(fifo_count), 32'd0);
      check("mr_valid0", 32'(out_valid), 32'd0);
      check("mr_ready1", 32'(in_ready), 32'd1);
      check("mr_busy0", 32'(busy), 32'd0);
      core_done  = 1'b1;
      core_class = 3'd4;
      tick;
      core_done  = 1'b0;
      repeat (3) tick;
      check("mr_late_done", 32'(out_valid), 32'd0);
      check("mr_late_busy", 32'(busy), 32'd0);
      check("mr_late_start", 32'(core_start), 32'd0);

`ifdef BNN_SCHED_STATS_EN
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("st_rst_c0", 32'(stat_class0), 32'd0);
      check("st_rst_to", 32'(stat_timeout), 32'd0);
      for (int i = 0; i < 300; i++) begin
         push(16'(i));
         wait_start;
         done_at(1, 3'd0, 4'(i));
         handshake;
      end
      for (int i = 0; i < 2; i++) begin
         push(16'hEEEE);
         wait_valid;
         handshake;
      end
      check("st_class0", 32'(stat_class0), 32'd255);
      check("st_class1", 32'(stat_class1), 32'd0);
      check("st_timeout", 32'(stat_timeout), 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
